// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Front-end controller for the PC register. Chooses which next-PC source the
//   PC generator loads (PCSrcs) and when it loads (enable). It also drives the
//   four candidate next-PC buses and the IF/ID flush pulses. A redirect that
//   arrives during a stall is held and replayed once the stall clears. HALT
//   parks the front end until reset.
//
//   Optional build macro: FETCH_SEQ_STATS_EN adds the redirect_cnt and
//   stall_cnt saturating counters.
//
// Ports
//   CLK           clock, all state updates on posedge
//   reset         synchronous, active-high
//   pc            current PC fed back from the PC register
//   stall         pipeline/memory stall; fetch must not advance
//   halt          HALT decoded in ID
//   br_req/br_target  taken branch resolved in EX
//   jr_req/jr_target  JR in ID
//   j_req/j_target    J/JAL in ID
//   PCSrcs        00=JR, 01=J/JAL, 10=branch, 11=sequential
//   enable        PC register load enable
//   pc0..pc3      candidate buses: JR, J, branch, pc+1
//   flush_if      kill the IF instruction (1-cycle pulse)
//   flush_id      kill the ID instruction (1-cycle pulse)
//   halted        high while halted
//   redirect_cnt  (FETCH_SEQ_STATS_EN) enabled redirects, replays included
//   stall_cnt     (FETCH_SEQ_STATS_EN) RUN/HOLD cycles with enable low
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int INST_MEM_WIDTH = 14
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic                      stall,
  input  logic                      halt,
  input  logic                      br_req,
  input  logic [INST_MEM_WIDTH-1:0] br_target,
  input  logic                      jr_req,
  input  logic [INST_MEM_WIDTH-1:0] jr_target,
  input  logic                      j_req,
  input  logic [INST_MEM_WIDTH-1:0] j_target,
  output logic [1:0]                PCSrcs,
  output logic                      enable,
  output logic [INST_MEM_WIDTH-1:0] pc0,
  output logic [INST_MEM_WIDTH-1:0] pc1,
  output logic [INST_MEM_WIDTH-1:0] pc2,
  output logic [INST_MEM_WIDTH-1:0] pc3,
  output logic                      flush_if,
  output logic                      flush_id,
  output logic                      halted
`ifdef FETCH_SEQ_STATS_EN
  ,
  output logic [31:0]               redirect_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam logic [1:0] SRC_JR  = 2'b00;
  localparam logic [1:0] SRC_J   = 2'b01;
  localparam logic [1:0] SRC_BR  = 2'b10;
  localparam logic [1:0] SRC_SEQ = 2'b11;
  localparam logic [INST_MEM_WIDTH-1:0] PC_ONE = INST_MEM_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HOLD   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_pend_vld;
  logic [1:0]                  r_pend_src;
  logic [INST_MEM_WIDTH-1:0]   r_pend_target;
  logic                        w_pend_load;
  logic                        w_pend_clr;
  logic [1:0]                  w_pend_src_nxt;
  logic [INST_MEM_WIDTH-1:0]   w_pend_target_nxt;
  logic                        w_replay;

  // State and pending-redirect registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_pend_vld    <= 1'b0;
      r_pend_src    <= SRC_SEQ;
      r_pend_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pend_clr) begin
        r_pend_vld <= 1'b0;
      end else if (w_pend_load) begin
        r_pend_vld    <= 1'b1;
        r_pend_src    <= w_pend_src_nxt;
        r_pend_target <= w_pend_target_nxt;
      end
    end
  end

  // Next-state, redirect arbitration and control outputs
  always_comb begin
    w_state_nxt       = r_state;
    PCSrcs            = SRC_SEQ;
    enable            = 1'b0;
    flush_if          = 1'b0;
    flush_id          = 1'b0;
    halted            = 1'b0;
    w_pend_load       = 1'b0;
    w_pend_clr        = 1'b0;
    w_pend_src_nxt    = SRC_SEQ;
    w_pend_target_nxt = '0;
    w_replay          = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // One dead cycle; a stall here has no effect.
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          // Capture the winning redirect. A halt under stall is not held:
          // the frozen pipeline presents it again once the stall clears.
          if (br_req) begin
            w_pend_load       = 1'b1;
            w_pend_src_nxt    = SRC_BR;
            w_pend_target_nxt = br_target;
            w_state_nxt       = ST_HOLD;
          end else if (jr_req) begin
            w_pend_load       = 1'b1;
            w_pend_src_nxt    = SRC_JR;
            w_pend_target_nxt = jr_target;
            w_state_nxt       = ST_HOLD;
          end else if (j_req) begin
            w_pend_load       = 1'b1;
            w_pend_src_nxt    = SRC_J;
            w_pend_target_nxt = j_target;
            w_state_nxt       = ST_HOLD;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else if (br_req) begin
          PCSrcs   = SRC_BR;
          enable   = 1'b1;
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (jr_req) begin
          PCSrcs   = SRC_JR;
          enable   = 1'b1;
          flush_if = 1'b1;
        end else if (j_req) begin
          PCSrcs   = SRC_J;
          enable   = 1'b1;
          flush_if = 1'b1;
        end else if (halt) begin
          w_state_nxt = ST_HALTED;
        end else begin
          enable = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stall) begin
          // Only a branch (older instruction, resolved in EX) may displace a
          // held JR/J; a held branch is never displaced.
          if (br_req && (r_pend_src != SRC_BR)) begin
            w_pend_load       = 1'b1;
            w_pend_src_nxt    = SRC_BR;
            w_pend_target_nxt = br_target;
          end else begin
            w_pend_load = 1'b0;
          end
        end else if (r_pend_vld) begin
          // Replay: live requests are ignored this cycle.
          w_replay    = 1'b1;
          PCSrcs      = r_pend_src;
          enable      = 1'b1;
          flush_if    = 1'b1;
          flush_id    = (r_pend_src == SRC_BR);
          w_pend_clr  = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // Candidate next-PC buses; the held target overrides its bus during replay
  always_comb begin
    pc3 = pc + PC_ONE;
    if (w_replay && (r_pend_src == SRC_JR)) begin
      pc0 = r_pend_target;
    end else begin
      pc0 = jr_target;
    end
    if (w_replay && (r_pend_src == SRC_J)) begin
      pc1 = r_pend_target;
    end else begin
      pc1 = j_target;
    end
    if (w_replay && (r_pend_src == SRC_BR)) begin
      pc2 = r_pend_target;
    end else begin
      pc2 = br_target;
    end
  end

`ifdef FETCH_SEQ_STATS_EN
  logic w_redirect_evt;
  logic w_stall_evt;

  assign w_redirect_evt = enable && (PCSrcs != SRC_SEQ);
  assign w_stall_evt    = !enable && ((r_state == ST_RUN) || (r_state == ST_HOLD));

  // Saturating event counters
  always_ff @(posedge CLK) begin
    if (reset) begin
      redirect_cnt <= 32'd0;
      stall_cnt    <= 32'd0;
    end else begin
      if (w_redirect_evt && (redirect_cnt != 32'hFFFF_FFFF)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
      if (w_stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int W = 14;

  logic         CLK = 1'b0;
  logic         reset;
  logic [W-1:0] pc;
  logic         stall, halt, br_req, jr_req, j_req;
  logic [W-1:0] br_target, jr_target, j_target;
  logic [1:0]   PCSrcs;
  logic         enable, flush_if, flush_id, halted;
  logic [W-1:0] pc0, pc1, pc2, pc3;
`ifdef FETCH_SEQ_STATS_EN
  logic [31:0]  redirect_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [1:0]   src;
    logic         en;
    logic         fi;
    logic         fid;
    logic         hlt;
    int           bus;
    logic [W-1:0] bus_val;
  } exp_t;

  exp_t exp_q[$];

  fetch_sequencer #(.INST_MEM_WIDTH(W)) dut (
    .CLK(CLK), .reset(reset), .pc(pc), .stall(stall), .halt(halt),
    .br_req(br_req), .br_target(br_target),
    .jr_req(jr_req), .jr_target(jr_target),
    .j_req(j_req), .j_target(j_target),
    .PCSrcs(PCSrcs), .enable(enable),
    .pc0(pc0), .pc1(pc1), .pc2(pc2), .pc3(pc3),
    .flush_if(flush_if), .flush_id(flush_id), .halted(halted)
`ifdef FETCH_SEQ_STATS_EN
    , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input string field, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, req);
    end
  endtask

  // Monitor: outputs are combinational within a cycle; sample at negedge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [W-1:0] bus_act;
      e = exp_q.pop_front();
      check(e.name, "PCSrcs",   int'(PCSrcs),   int'(e.src));
      check(e.name, "enable",   int'(enable),   int'(e.en));
      check(e.name, "flush_if", int'(flush_if), int'(e.fi));
      check(e.name, "flush_id", int'(flush_id), int'(e.fid));
      check(e.name, "halted",   int'(halted),   int'(e.hlt));
      case (e.bus)
        0: bus_act = pc0;
        1: bus_act = pc1;
        2: bus_act = pc2;
        default: bus_act = pc3;
      endcase
      check(e.name, $sformatf("pc%0d", e.bus), int'(bus_act), int'(e.bus_val));
    end
  end

  task automatic clr_req();
    br_req = 1'b0; jr_req = 1'b0; j_req = 1'b0; halt = 1'b0; stall = 1'b0;
  endtask

  // Push the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string name, input logic [1:0] src, input logic en,
                     input logic fi, input logic fid, input logic hlt,
                     input int bus, input logic [W-1:0] bus_val);
    exp_t e;
    e.name = name; e.src = src; e.en = en; e.fi = fi; e.fid = fid;
    e.hlt = hlt; e.bus = bus; e.bus_val = bus_val;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc = 14'd5;
    br_target = 14'h0; jr_target = 14'h0; j_target = 14'h0;
    clr_req();
    @(posedge CLK);
    #1;

    // 1. reset state and boot
    cyc("reset",  2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 14'd6);
    reset = 1'b0;
    cyc("boot",   2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 14'd6);
    cyc("seq5",   2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3, 14'd6);
    pc = 14'd6;
    cyc("seq6",   2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3, 14'd7);

    // 2. branch beats J
    br_req = 1'b1; br_target = 14'h40; j_req = 1'b1; j_target = 14'h33;
    cyc("br_vs_j", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 2, 14'h40);
    clr_req(); jr_req = 1'b1; jr_target = 14'h21; j_req = 1'b1;
    cyc("jr_vs_j", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 14'h21);
    clr_req(); j_req = 1'b1; j_target = 14'h55; halt = 1'b1;
    cyc("j_vs_halt", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1, 14'h55);

    // 3. JR held across a 3-cycle stall
    clr_req(); stall = 1'b1; jr_req = 1'b1; jr_target = 14'h12;
    cyc("jr_stall1", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 14'h12);
    cyc("jr_stall2", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 14'h12);
    cyc("jr_stall3", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 14'h12);
    stall = 1'b0; jr_target = 14'h99;
    cyc("jr_replay", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 14'h12);
    clr_req();
    cyc("post_jr",   2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3, 14'd7);

    // 4. pending J displaced by a branch; later JR ignored
    stall = 1'b1; j_req = 1'b1; j_target = 14'h2A;
    cyc("j_hold",    2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 14'h2A);
    clr_req(); stall = 1'b1; br_req = 1'b1; br_target = 14'h77;
    cyc("br_over_j", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 14'h77);
    clr_req(); stall = 1'b1; jr_req = 1'b1; jr_target = 14'h10;
    cyc("jr_ignored", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 14'h10);
    clr_req(); br_target = 14'h01;
    cyc("br_replay", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 2, 14'h77);

    // held branch is not displaced by a second branch
    stall = 1'b1; br_req = 1'b1; br_target = 14'h11;
    cyc("br_hold",   2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 14'h11);
    br_target = 14'h22;
    cyc("br_keep",   2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 14'h22);
    clr_req();
    cyc("br_replay2", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 2, 14'h11);

    // 5. pc wrap and halt
    pc = 14'h3FFF;
    cyc("wrap",      2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3, 14'h0);
    halt = 1'b1;
    cyc("halt_req",  2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 14'h0);
    clr_req(); br_req = 1'b1; br_target = 14'h50;
    cyc("halted1",   2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 3, 14'h0);
    clr_req();
    cyc("halted2",   2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 3, 14'h0);

    // 6. reset during HOLD discards the pending redirect
    pc = 14'd8; reset = 1'b1;
    cyc("rst_halt",  2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 3, 14'd9);
    reset = 1'b0;
    cyc("boot2",     2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 14'd9);
    cyc("run2",      2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3, 14'd9);
    stall = 1'b1; jr_req = 1'b1; jr_target = 14'h12;
    cyc("hold2a",    2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 14'h12);
    cyc("hold2b",    2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 14'h12);
    clr_req(); stall = 1'b1; reset = 1'b1;
    cyc("rst_hold",  2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 14'd9);
    reset = 1'b0; stall = 1'b1; jr_target = 14'h05;
    cyc("boot3_stall", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 14'd9);
    stall = 1'b0;
    cyc("no_replay", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 14'h05);
    cyc("run3",      2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3, 14'd9);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(posedge CLK);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
